mc_exe_control: RTL and testbench
=================================

Name: mc_exe_control

Overview:
- Multi-cycle control FSM that sequences the EXE-stage datapath: the ALU, the branch-target adder and the register/memory write-back path.
- Decodes opcode/funct.
- Drives ALU_operation and the operand, PC and write-back selects.
- Holds memory accesses with a ready handshake and traps on illegal instructions or memory timeouts.

Parameters:
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready in any memory state; 0 disables the timeout.
- OP_W, 6, width of the opcode and funct fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OP_W  instruction bits [31:26], valid from DECODE onward.
- funct  in  OP_W  instruction bits [5:0].
- Zero_signal  in  1  ALU zero flag (1 when ALU_result==0).
- mem_ready  in  1  memory completion strobe.
- ALU_operation  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- alu_src_b  out  1  0=data_read_2, 1=INM32.
- pc_write  out  1  PC load enable.
- pc_src  out  2  0=PCNext, 1=branch_target, 2=jump target.
- ir_write  out  1  instruction register load.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_addr_sel  out  1  0=PC, 1=ALU_result.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALU_result, 1=memory data.
- instr_done  out  1  one-cycle pulse per retired instruction.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  01 illegal op, 10 memory timeout.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; the timeout counter clears; trap and trap_cause clear.
  - All outputs are 0, and ALU_operation=0000.
- Outputs are a Moore decode of the registered state. Exceptions: pc_write in BRANCH, and mem_read/mem_write/ir_write qualification as stated below.
- States and transitions:
  - IDLE: next state FETCH.
  - FETCH:
    - mem_read=1, mem_addr_sel=0.
    - If mem_ready=1: ir_write=1, pc_write=1, pc_src=0, and go to DECODE. Otherwise stay.
  - DECODE: all controls 0. Decode and go to:
    - R-type (000000) -> EXEC_R.
    - lw (100011) or sw (101011) -> ADDR.
    - addi (001000) -> EXEC_I.
    - beq (000100) -> BRANCH.
    - j (000010) -> JUMP.
    - Anything else -> TRAP with cause 01.
  - EXEC_R:
    - alu_src_b=0.
    - funct map: 100100->AND, 100101->OR, 100000->ADD, 100010->SUB, 101010->SLT. Any other funct -> TRAP with cause 01.
    - Next state WB_R.
  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
  - EXEC_I: ADD, alu_src_b=1. Next state WB_I.
  - WB_I: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
  - ADDR: ADD, alu_src_b=1. Next state MEM_RD for lw, MEM_WR for sw.
  - MEM_RD:
    - ADD, alu_src_b=1, mem_read=1, mem_addr_sel=1.
    - On mem_ready go to WB_M.
  - WB_M: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next state FETCH.
  - MEM_WR:
    - mem_write=1, mem_addr_sel=1, ALU still ADD with alu_src_b=1.
    - On mem_ready: instr_done=1, go to FETCH.
  - BRANCH:
    - SUB, alu_src_b=0, pc_src=1.
    - pc_write=Zero_signal (combinational in this state).
    - instr_done=1. Next state FETCH.
  - JUMP: pc_src=2, pc_write=1, instr_done=1. Next state FETCH.
  - TRAP:
    - All controls 0; trap=1.
    - trap_cause holds the first cause.
    - Only reset exits TRAP.
- Memory handshake:
  - Requests stay asserted and stable until the cycle mem_ready=1 is sampled.
  - A mem_ready seen outside FETCH, MEM_RD or MEM_WR is ignored.
  - mem_ready already high on state entry completes the access in 1 cycle.
- Timeout:
  - The counter clears on entry to each memory state and increments on each cycle without ready.
  - If MEM_TIMEOUT!=0 and the count reaches MEM_TIMEOUT with no ready, go to TRAP with cause 10.
  - Ready arriving in the same cycle the count reaches MEM_TIMEOUT wins; the access completes normally.
- Latency:
  - R/addi/sw: 4 cycles with zero-wait memory.
  - lw: 5 cycles.
  - beq and j: 3 cycles.
- Reset asserted mid-instruction aborts immediately. No partial write occurs after the reset edge.

Optional Feature:
- Macro: MC_EXE_BNE_EN.
- Defined:
  - Opcode 000101 (bne) decodes to BRANCH_NE.
  - BRANCH_NE behaves like BRANCH except pc_write=~Zero_signal.
- Undefined: 000101 is illegal -> TRAP with cause 01.

Test Plan:
- Reset release, mem_ready=1 constant -> IDLE for 1 cycle, then FETCH with mem_read=1, ir_write=1, pc_write=1; all outputs 0 while rst_n=0.
- R-type funct=100010, zero-wait -> EXEC_R with ALU_operation=0110, then WB_R with reg_write=1, reg_dst=1, instr_done=1; 4 cycles total.
- lw with mem_ready low for 3 cycles in MEM_RD -> mem_read=1 and mem_addr_sel=1 held for 4 cycles, then WB_M with mem_to_reg=1.
- beq with Zero_signal=1 -> pc_write=1, pc_src=1. Repeat with Zero_signal=0 -> pc_write=0 and next state FETCH.
- sw with mem_ready never asserted, MEM_TIMEOUT=15 -> TRAP after 15 wait cycles with trap_cause=10. opcode=111111 -> TRAP with cause 01. rst_n=0 clears both.
- MC_EXE_BNE_EN defined, opcode=000101, Zero_signal=0 -> pc_write=1. Same opcode with macro undefined -> trap_cause=01.

Source files
------------

// File: rtl/mc_exe_control.sv
`default_nettype none
// ============================================================================
// mc_exe_control : multi-cycle control FSM sequencing the EXE-stage datapath
// Optional macro MC_EXE_BNE_EN adds bne (000101).          Rev 1.0
// ============================================================================
module mc_exe_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int OP_W        = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  input  logic            Zero_signal,
  input  logic            mem_ready,
  output logic [3:0]      ALU_operation,
  output logic            alu_src_b,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_addr_sel,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            instr_done,
  output logic            trap,
  output logic [1:0]      trap_cause
);

  localparam int CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TMO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_LAST);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`ifdef MC_EXE_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
`endif

  localparam logic [OP_W-1:0] F_AND = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] F_OR  = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] F_ADD = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] F_SUB = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] F_SLT = OP_W'(6'b101010);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_TMO = 2'b10;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR,
    MEM_RD, WB_M, MEM_WR, BRANCH, BRANCH_NE, JUMP, TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [1:0]       pc_src_q, pc_src_d;
  logic             alu_src_b_q, alu_src_b_d;
  logic             pc_write_q, pc_write_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             addr_sel_q, addr_sel_d;
  logic             reg_write_q, reg_write_d;
  logic             reg_dst_q, reg_dst_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             done_q, done_d;
  logic             trap_q, trap_d;

  logic       funct_ok;
  logic [3:0] funct_op;
  logic       in_mem;
  logic       tmo_hit;
  logic       fetch_go;
  logic       br_take;

  always_comb begin
    funct_ok = 1'b1;
    funct_op = ALU_AND;
    case (funct)
      F_AND:   funct_op = ALU_AND;
      F_OR:    funct_op = ALU_OR;
      F_ADD:   funct_op = ALU_ADD;
      F_SUB:   funct_op = ALU_SUB;
      F_SLT:   funct_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  assign in_mem  = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  // Fires on the last allowed wait cycle; a ready in that same cycle still wins.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST) && !mem_ready;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        if (mem_ready)    state_d = DECODE;
        else if (tmo_hit) begin state_d = TRAP; cause_d = CAUSE_TMO; end
      end
      DECODE: begin
        if (opcode == OP_RTYPE)                         state_d = EXEC_R;
        else if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = ADDR;
        else if (opcode == OP_ADDI)                     state_d = EXEC_I;
        else if (opcode == OP_BEQ)                      state_d = BRANCH;
        else if (opcode == OP_J)                        state_d = JUMP;
`ifdef MC_EXE_BNE_EN
        else if (opcode == OP_BNE)                      state_d = BRANCH_NE;
`endif
        else begin state_d = TRAP; cause_d = CAUSE_ILL; end
      end
      EXEC_R: begin
        if (funct_ok) state_d = WB_R;
        else begin state_d = TRAP; cause_d = CAUSE_ILL; end
      end
      EXEC_I: state_d = WB_I;
      ADDR:   state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD: begin
        if (mem_ready)    state_d = WB_M;
        else if (tmo_hit) begin state_d = TRAP; cause_d = CAUSE_TMO; end
      end
      MEM_WR: begin
        if (mem_ready)    state_d = FETCH;
        else if (tmo_hit) begin state_d = TRAP; cause_d = CAUSE_TMO; end
      end
      WB_R, WB_I, WB_M, BRANCH, BRANCH_NE, JUMP: state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)                          cnt_d = '0;
    else if (in_mem && !mem_ready && MEM_TIMEOUT != 0) cnt_d = cnt_q + 1'b1;
    else                                             cnt_d = cnt_q;
  end

  // Moore controls are computed for the state being entered so they are flops.
  always_comb begin
    alu_op_d     = ALU_AND;
    alu_src_b_d  = 1'b0;
    pc_write_d   = 1'b0;
    pc_src_d     = 2'd0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    addr_sel_d   = 1'b0;
    reg_write_d  = 1'b0;
    reg_dst_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    done_d       = 1'b0;
    trap_d       = 1'b0;
    case (state_d)
      FETCH:  mem_read_d = 1'b1;
      EXEC_R: alu_op_d = funct_op;
      WB_R:   begin reg_write_d = 1'b1; reg_dst_d = 1'b1; done_d = 1'b1; end
      EXEC_I, ADDR: begin alu_op_d = ALU_ADD; alu_src_b_d = 1'b1; end
      WB_I:   begin reg_write_d = 1'b1; done_d = 1'b1; end
      MEM_RD: begin
        alu_op_d = ALU_ADD; alu_src_b_d = 1'b1; mem_read_d = 1'b1; addr_sel_d = 1'b1;
      end
      WB_M:   begin reg_write_d = 1'b1; mem_to_reg_d = 1'b1; done_d = 1'b1; end
      MEM_WR: begin
        alu_op_d = ALU_ADD; alu_src_b_d = 1'b1; mem_write_d = 1'b1; addr_sel_d = 1'b1;
      end
      BRANCH, BRANCH_NE: begin alu_op_d = ALU_SUB; pc_src_d = 2'd1; done_d = 1'b1; end
      JUMP:   begin pc_src_d = 2'd2; pc_write_d = 1'b1; done_d = 1'b1; end
      TRAP:   trap_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cause_q      <= 2'b00;
      alu_op_q     <= ALU_AND;
      alu_src_b_q  <= 1'b0;
      pc_write_q   <= 1'b0;
      pc_src_q     <= 2'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_sel_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      done_q       <= 1'b0;
      trap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cause_q      <= cause_d;
      alu_op_q     <= alu_op_d;
      alu_src_b_q  <= alu_src_b_d;
      pc_write_q   <= pc_write_d;
      pc_src_q     <= pc_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      addr_sel_q   <= addr_sel_d;
      reg_write_q  <= reg_write_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      done_q       <= done_d;
      trap_q       <= trap_d;
    end
  end

  assign fetch_go = (state_q == FETCH) && mem_ready;

  always_comb begin
    br_take = (state_q == BRANCH) && Zero_signal;
`ifdef MC_EXE_BNE_EN
    br_take = br_take || ((state_q == BRANCH_NE) && !Zero_signal);
`endif
  end

  assign ALU_operation = alu_op_q;
  assign alu_src_b     = alu_src_b_q;
  assign pc_write      = pc_write_q | fetch_go | br_take;
  assign pc_src        = pc_src_q;
  assign ir_write      = fetch_go;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_addr_sel  = addr_sel_q;
  assign reg_write     = reg_write_q;
  assign reg_dst       = reg_dst_q;
  assign mem_to_reg    = mem_to_reg_q;
  assign instr_done    = done_q | ((state_q == MEM_WR) && mem_ready);
  assign trap          = trap_q;
  assign trap_cause    = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_exe_control.sv
`default_nettype none
// tb_mc_exe_control : randomized scoreboard bench; expected retirements are
// queued by the driver and compared by an independent negedge monitor.
module tb_mc_exe_control;

  localparam int TMO = 15;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                         A_SUB = 4'b0110, A_SLT = 4'b0111;
  localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_BNE = 6;

  typedef struct {
    bit         is_trap;
    logic [1:0] cause;
    int         lat;
    logic       rw, rdst, m2r, pcw;
    logic [1:0] pcs;
    logic [3:0] alu;
    int         rd_cyc, wr_cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       Zero_signal = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] ALU_operation;
  logic       alu_src_b, pc_write, ir_write, mem_read, mem_write, mem_addr_sel;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, trap;
  logic [1:0] pc_src, trap_cause;
  logic [15:0] ctrl;
  logic [18:0] outs;

  assign ctrl = {ALU_operation, alu_src_b, pc_write, pc_src, ir_write, mem_read, mem_write,
                 mem_addr_sel, reg_write, reg_dst, mem_to_reg, instr_done};
  assign outs = {ctrl, trap, trap_cause};

  always #5 clk = ~clk;

  mc_exe_control #(.MEM_TIMEOUT(TMO), .OP_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .Zero_signal(Zero_signal), .mem_ready(mem_ready),
    .ALU_operation(ALU_operation), .alu_src_b(alu_src_b), .pc_write(pc_write),
    .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr_sel(mem_addr_sel), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100100: return A_AND;
      6'b100101: return A_OR;
      6'b100000: return A_ADD;
      6'b100010: return A_SUB;
      default:   return A_SLT;
    endcase
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e.is_trap = 1'b0; e.cause = 2'b00; e.lat = 0;
    e.rw = 1'b0; e.rdst = 1'b0; e.m2r = 1'b0; e.pcw = 1'b0;
    e.pcs = 2'd0; e.alu = A_AND; e.rd_cyc = 0; e.wr_cyc = 0;
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick(input logic rdy);
    mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("reset_outputs", 32'(outs), 32'(0));
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    sb.delete();
    @(negedge clk);
    #2;
    mem_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("idle_outputs", 32'(outs), 32'(0));
    @(posedge clk);
    #1;
  endtask

  // zs/fo/wo < 0 select a random value.
  task automatic run_instr(input int kind, input int zs, input int fo, input int wo);
    exp_t e;
    int w, fw;
    logic z;
    logic [5:0] f, opc;
    e  = blank();
    fw = $urandom_range(0, 2);
    if (wo >= 0) w = wo;
    else w = ($urandom_range(0, 4) == 0) ? TMO - 1 : $urandom_range(0, 3);
    z = (zs >= 0) ? zs[0] : rbit();
    if (fo >= 0) f = fo[5:0];
    else begin
      case ($urandom_range(0, 4))
        0: f = 6'b100100;
        1: f = 6'b100101;
        2: f = 6'b100000;
        3: f = 6'b100010;
        default: f = 6'b101010;
      endcase
    end
    case (kind)
      K_R:    begin opc = 6'b000000; e.lat = 3; e.rw = 1'b1; e.rdst = 1'b1; e.alu = alu_of(f); end
      K_ADDI: begin opc = 6'b001000; e.lat = 3; e.rw = 1'b1; e.alu = A_ADD; end
      K_LW:   begin opc = 6'b100011; e.lat = 4 + w; e.rw = 1'b1; e.m2r = 1'b1; e.alu = A_ADD; e.rd_cyc = w + 1; end
      K_SW:   begin opc = 6'b101011; e.lat = 3 + w; e.alu = A_ADD; e.wr_cyc = w + 1; end
      K_BEQ:  begin opc = 6'b000100; e.lat = 2; e.pcw = z; e.pcs = 2'd1; e.alu = A_SUB; end
      K_J:    begin opc = 6'b000010; e.lat = 2; e.pcw = 1'b1; e.pcs = 2'd2; end
      default: begin opc = 6'b000101; e.lat = 2; e.pcw = ~z; e.pcs = 2'd1; e.alu = A_SUB; end
    endcase
    sb.push_back(e);
    opcode = opc; funct = f; Zero_signal = z;
    repeat (fw) tick(1'b0);
    tick(1'b1);
    tick(rbit());
    case (kind)
      K_R, K_ADDI: begin tick(rbit()); tick(rbit()); end
      K_LW: begin tick(rbit()); repeat (w) tick(1'b0); tick(1'b1); tick(rbit()); end
      K_SW: begin tick(rbit()); repeat (w) tick(1'b0); tick(1'b1); end
      default: tick(rbit());
    endcase
  endtask

  // mode: 0 bad opcode, 1 bad funct, 2 lw timeout, 3 sw timeout, 4 bne opcode (feature off)
  task automatic run_trap(input int mode);
    exp_t e;
    e = blank();
    e.is_trap = 1'b1;
    funct = 6'b100000;
    case (mode)
      0: begin opcode = 6'b111111; e.cause = 2'b01; e.lat = 2; end
      1: begin opcode = 6'b000000; funct = 6'b111111; e.cause = 2'b01; e.lat = 3; end
      2: begin opcode = 6'b100011; e.cause = 2'b10; e.lat = 3 + TMO; end
      3: begin opcode = 6'b101011; e.cause = 2'b10; e.lat = 3 + TMO; end
      default: begin opcode = 6'b000101; e.cause = 2'b01; e.lat = 2; end
    endcase
    sb.push_back(e);
    tick(1'b1);
    tick(rbit());
    if (mode == 2 || mode == 3) begin
      tick(rbit());
      repeat (TMO + 3) tick(1'b0);
    end else begin
      repeat (5) tick(rbit());
    end
    chk("trap_sticky", 32'(trap), 32'(1));
    chk("trap_cause_held", 32'(trap_cause), 32'(e.cause));
    chk("trap_controls_quiet", 32'(ctrl), 32'(0));
    do_reset();
  endtask

  task automatic run_abort();
    opcode = 6'b101011; funct = 6'b100000;
    tick(1'b1);
    tick(rbit());
    tick(rbit());
    tick(1'b0);
    tick(1'b0);
    chk("abort_write_active", 32'(mem_write), 32'(1));
    do_reset();
  endtask

  int         since = 0;
  int         rd_cyc = 0;
  int         wr_cyc = 0;
  logic [3:0] alu_snap = '0;
  logic       trap_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      since = 0; rd_cyc = 0; wr_cyc = 0; alu_snap = '0; trap_prev = 1'b0;
    end else begin
      if (ir_write) begin since = 0; rd_cyc = 0; wr_cyc = 0; end
      else since++;
      if (since == 2) alu_snap = ALU_operation;
      if (mem_read && mem_addr_sel) rd_cyc++;
      if (mem_write) wr_cyc++;
      if (instr_done) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got retirement, expected none");
        end else begin
          e = sb.pop_front();
          chk("event_kind", 32'(trap), 32'(e.is_trap));
          chk("latency", 32'(since), 32'(e.lat));
          chk("reg_write", 32'(reg_write), 32'(e.rw));
          chk("reg_dst", 32'(reg_dst), 32'(e.rdst));
          chk("mem_to_reg", 32'(mem_to_reg), 32'(e.m2r));
          chk("pc_write", 32'(pc_write), 32'(e.pcw));
          chk("pc_src", 32'(pc_src), 32'(e.pcs));
          chk("alu_op", 32'(alu_snap), 32'(e.alu));
          chk("mem_rd_cycles", 32'(rd_cyc), 32'(e.rd_cyc));
          chk("mem_wr_cycles", 32'(wr_cyc), 32'(e.wr_cyc));
        end
      end
      if (trap && !trap_prev) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_trap: got trap cause %0h, expected none", trap_cause);
        end else begin
          e = sb.pop_front();
          chk("trap_event_kind", 32'(trap), 32'(e.is_trap));
          chk("trap_cause", 32'(trap_cause), 32'(e.cause));
          chk("trap_latency", 32'(since), 32'(e.lat));
        end
      end
      trap_prev = trap;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nk;
`ifdef MC_EXE_BNE_EN
    nk = 7;
`else
    nk = 6;
`endif
    #3;
    chk("reset_hold_outputs", 32'(outs), 32'(0));
    do_reset();
    run_instr(K_R, -1, 'h22, 0);
    run_instr(K_LW, -1, -1, 3);
    run_instr(K_BEQ, 1, -1, -1);
    run_instr(K_BEQ, 0, -1, -1);
    run_instr(K_SW, -1, -1, TMO - 1);
    run_instr(K_LW, -1, -1, TMO - 1);
    run_instr(K_J, -1, -1, -1);
    run_instr(K_ADDI, -1, -1, 0);
`ifdef MC_EXE_BNE_EN
    run_instr(K_BNE, 0, -1, -1);
    run_instr(K_BNE, 1, -1, -1);
`endif
    repeat (40) run_instr($urandom_range(0, nk - 1), -1, -1, -1);
    run_trap(3);
    run_trap(0);
    run_trap(1);
    run_trap(2);
`ifndef MC_EXE_BNE_EN
    run_trap(4);
`endif
    repeat (5) run_instr($urandom_range(0, nk - 1), -1, -1, -1);
    run_abort();
    repeat (5) run_instr($urandom_range(0, nk - 1), -1, -1, -1);
    repeat (3) @(negedge clk);
    chk("final_scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
